// File: rtl/decoder_proj_formal_top.sv
// Registered 3-to-8 decoder (one-hot / thermometer / 7-seg / hold) with optional
// output inversion, a shadow-model self-checker and a sticky per-address coverage map.
module decoder_proj_formal_top (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [6:0] io_in,
  output logic [7:0] dec_out,
  output logic       dec_valid,
  output logic       chk_err,
  output logic [7:0] cov_hits
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SEG    = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic       inv;
    logic       en;
    logic [2:0] addr;
  } req_t;

  req_t req;
  assign req = req_t'(io_in);

  function automatic logic [7:0] seg7(input logic [2:0] a);
    case (a)
      3'd0:    seg7 = 8'h3F;
      3'd1:    seg7 = 8'h06;
      3'd2:    seg7 = 8'h5B;
      3'd3:    seg7 = 8'h4F;
      3'd4:    seg7 = 8'h66;
      3'd5:    seg7 = 8'h6D;
      3'd6:    seg7 = 8'h7D;
      default: seg7 = 8'h07;
    endcase
  endfunction

  // Primary datapath: arithmetic one-hot / thermometer generation.
  logic [7:0] dec_d, dec_nxt;
  logic [8:0] therm;
  always_comb begin
    therm = (9'h002 << req.addr) - 9'h001;
    dec_d = 8'h00;
    if (req.en) begin
      case (req.mode)
        MODE_ONEHOT: dec_d = 8'h01 << req.addr;
        MODE_THERM:  dec_d = therm[7:0];
        MODE_SEG:    dec_d = seg7(req.addr);
        default:     dec_d = 8'h00;
      endcase
    end
    dec_nxt = req.inv ? ~dec_d : dec_d;
  end

  // Shadow model: flat lookup on {mode, addr}, deliberately sharing no logic
  // with the primary path so a datapath fault shows up as a mismatch.
  logic [7:0] sh_d, sh_nxt;
  always_comb begin
    case ({req.mode, req.addr})
      5'b00_000: sh_d = 8'b0000_0001;
      5'b00_001: sh_d = 8'b0000_0010;
      5'b00_010: sh_d = 8'b0000_0100;
      5'b00_011: sh_d = 8'b0000_1000;
      5'b00_100: sh_d = 8'b0001_0000;
      5'b00_101: sh_d = 8'b0010_0000;
      5'b00_110: sh_d = 8'b0100_0000;
      5'b00_111: sh_d = 8'b1000_0000;
      5'b01_000: sh_d = 8'b0000_0001;
      5'b01_001: sh_d = 8'b0000_0011;
      5'b01_010: sh_d = 8'b0000_0111;
      5'b01_011: sh_d = 8'b0000_1111;
      5'b01_100: sh_d = 8'b0001_1111;
      5'b01_101: sh_d = 8'b0011_1111;
      5'b01_110: sh_d = 8'b0111_1111;
      5'b01_111: sh_d = 8'b1111_1111;
      5'b10_000: sh_d = 8'b0011_1111;
      5'b10_001: sh_d = 8'b0000_0110;
      5'b10_010: sh_d = 8'b0101_1011;
      5'b10_011: sh_d = 8'b0100_1111;
      5'b10_100: sh_d = 8'b0110_0110;
      5'b10_101: sh_d = 8'b0110_1101;
      5'b10_110: sh_d = 8'b0111_1101;
      5'b10_111: sh_d = 8'b0000_0111;
      default:   sh_d = 8'b0000_0000;
    endcase
    if (!req.en) sh_d = 8'h00;
    sh_nxt = req.inv ? ~sh_d : sh_d;
  end

  logic [7:0] shadow;
  logic       chk_armed;
  mode_e      mode_q;
  logic       inv_q;
  logic       pop_err;

  // One-hot sanity: a valid mode-00 result must carry exactly one active bit.
  assign pop_err = dec_valid && (mode_q == MODE_ONEHOT) &&
                   ($countones(inv_q ? ~dec_out : dec_out) != 1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dec_out   <= 8'h00;
      dec_valid <= 1'b0;
      chk_err   <= 1'b0;
      cov_hits  <= 8'h00;
      shadow    <= 8'h00;
      chk_armed <= 1'b0;
      mode_q    <= MODE_ONEHOT;
      inv_q     <= 1'b0;
    end else begin
      chk_armed <= 1'b1;
      dec_valid <= req.en && (req.mode != MODE_HOLD);
      if (req.mode != MODE_HOLD) begin
        dec_out <= dec_nxt;
        shadow  <= sh_nxt;
        mode_q  <= req.mode;
        inv_q   <= req.inv;
        if (req.en) cov_hits[req.addr] <= 1'b1;
      end
      if (chk_armed && ((dec_out != shadow) || pop_err)) chk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_proj_formal_top.sv
// Directed bench for decoder_proj_formal_top: one task per scenario, expected
// values hand-computed from the decode tables.
module tb_decoder_proj_formal_top;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [6:0] io_in;
  logic [7:0] dec_out;
  logic       dec_valid;
  logic       chk_err;
  logic [7:0] cov_hits;

  int n_chk  = 0;
  int n_pass = 0;

  decoder_proj_formal_top dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .io_in    (io_in),
    .dec_out  (dec_out),
    .dec_valid(dec_valid),
    .chk_err  (chk_err),
    .cov_hits (cov_hits)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    io_in    = 7'b00_0_1_011;
    tick();
    tick();
    n_chk++; if (dec_out !== 8'h00) $display("FAIL reset_dec_out got=%h exp=00", dec_out); else n_pass++;
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dec_valid); else n_pass++;
    n_chk++; if (chk_err !== 1'b0) $display("FAIL reset_chk_err got=%b exp=0", chk_err); else n_pass++;
    n_chk++; if (cov_hits !== 8'h00) $display("FAIL reset_cov got=%h exp=00", cov_hits); else n_pass++;
    wb_rst_i = 1'b0;
  endtask

  task automatic test_onehot();
    io_in = 7'b00_0_1_011;
    tick();
    n_chk++; if (dec_out !== 8'h08) $display("FAIL onehot_dec_out got=%h exp=08", dec_out); else n_pass++;
    n_chk++; if (dec_valid !== 1'b1) $display("FAIL onehot_valid got=%b exp=1", dec_valid); else n_pass++;
    n_chk++; if (cov_hits !== 8'h08) $display("FAIL onehot_cov got=%h exp=08", cov_hits); else n_pass++;
    n_chk++; if (chk_err !== 1'b0) $display("FAIL onehot_chk_err got=%b exp=0", chk_err); else n_pass++;
  endtask

  task automatic test_hold();
    io_in = 7'b1100100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (dec_out !== 8'h08) $display("FAIL hold_dec_out[%0d] got=%h exp=08", i, dec_out); else n_pass++;
      n_chk++; if (dec_valid !== 1'b0) $display("FAIL hold_valid[%0d] got=%b exp=0", i, dec_valid); else n_pass++;
      n_chk++; if (cov_hits !== 8'h08) $display("FAIL hold_cov[%0d] got=%h exp=08", i, cov_hits); else n_pass++;
    end
  endtask

  task automatic test_therm_inv();
    io_in = 7'b01_1_1_101;
    tick();
    n_chk++; if (dec_out !== 8'hC0) $display("FAIL therm_inv_dec_out got=%h exp=c0", dec_out); else n_pass++;
    n_chk++; if (dec_valid !== 1'b1) $display("FAIL therm_inv_valid got=%b exp=1", dec_valid); else n_pass++;
    n_chk++; if (cov_hits !== 8'h28) $display("FAIL therm_inv_cov got=%h exp=28", cov_hits); else n_pass++;
    io_in = 7'b01_0_1_111;
    tick();
    n_chk++; if (dec_out !== 8'hFF) $display("FAIL therm_a7 got=%h exp=ff", dec_out); else n_pass++;
    io_in = 7'b01_0_1_000;
    tick();
    n_chk++; if (dec_out !== 8'h01) $display("FAIL therm_a0 got=%h exp=01", dec_out); else n_pass++;
    n_chk++; if (cov_hits !== 8'hA9) $display("FAIL therm_cov got=%h exp=a9", cov_hits); else n_pass++;
  endtask

  task automatic test_en_off();
    io_in = 7'b00_1_0_010;
    tick();
    n_chk++; if (dec_out !== 8'hFF) $display("FAIL enoff_inv_dec_out got=%h exp=ff", dec_out); else n_pass++;
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL enoff_valid got=%b exp=0", dec_valid); else n_pass++;
    n_chk++; if (cov_hits !== 8'hA9) $display("FAIL enoff_cov got=%h exp=a9", cov_hits); else n_pass++;
    io_in = 7'b00_0_0_010;
    tick();
    n_chk++; if (dec_out !== 8'h00) $display("FAIL enoff_dec_out got=%h exp=00", dec_out); else n_pass++;
    n_chk++; if (chk_err !== 1'b0) $display("FAIL enoff_chk_err got=%b exp=0", chk_err); else n_pass++;
  endtask

  task automatic test_sevenseg();
    logic [7:0] seg_tab [8];
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    for (int a = 0; a < 8; a++) begin
      io_in = {2'b10, 1'b0, 1'b1, 3'(a)};
      tick();
      n_chk++; if (dec_out !== seg_tab[a]) $display("FAIL seg_dec_out[%0d] got=%h exp=%h", a, dec_out, seg_tab[a]); else n_pass++;
      n_chk++; if (dec_valid !== 1'b1) $display("FAIL seg_valid[%0d] got=%b exp=1", a, dec_valid); else n_pass++;
    end
    n_chk++; if (cov_hits !== 8'hFF) $display("FAIL seg_cov got=%h exp=ff", cov_hits); else n_pass++;
    n_chk++; if (chk_err !== 1'b0) $display("FAIL seg_chk_err got=%b exp=0", chk_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    io_in = 7'b00_0_1_101;
    tick();
    n_chk++; if (dec_out !== 8'h20) $display("FAIL mid_pre_dec_out got=%h exp=20", dec_out); else n_pass++;
    wb_rst_i = 1'b1;
    io_in    = 7'b00_0_1_110;
    tick();
    n_chk++; if (dec_out !== 8'h00) $display("FAIL mid_rst_dec_out got=%h exp=00", dec_out); else n_pass++;
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", dec_valid); else n_pass++;
    n_chk++; if (cov_hits !== 8'h00) $display("FAIL mid_rst_cov got=%h exp=00", cov_hits); else n_pass++;
    wb_rst_i = 1'b0;
    io_in    = 7'b11_1_1_101;
    tick();
    n_chk++; if (dec_out !== 8'h00) $display("FAIL hold_after_rst got=%h exp=00", dec_out); else n_pass++;
    n_chk++; if (cov_hits !== 8'h00) $display("FAIL hold_after_rst_cov got=%h exp=00", cov_hits); else n_pass++;
    io_in = 7'b00_0_1_010;
    tick();
    n_chk++; if (dec_out !== 8'h04) $display("FAIL mid_post_dec_out got=%h exp=04", dec_out); else n_pass++;
    n_chk++; if (cov_hits !== 8'h04) $display("FAIL mid_post_cov got=%h exp=04", cov_hits); else n_pass++;
    io_in = 7'b00_1_1_111;
    tick();
    n_chk++; if (dec_out !== 8'h7F) $display("FAIL onehot_inv got=%h exp=7f", dec_out); else n_pass++;
    tick();
    n_chk++; if (chk_err !== 1'b0) $display("FAIL mid_chk_err got=%b exp=0", chk_err); else n_pass++;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    io_in    = 7'd0;
    @(negedge wb_clk_i);
    test_reset();
    test_onehot();
    test_hold();
    test_therm_inv();
    test_en_off();
    test_sevenseg();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
